// File: rtl/regfile_pkg.sv
// Shared defaults and the address-width helper for the multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;

    function automatic int addr_width(input int n);
        int w;
        w = 0;
        while ((32'sd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read, writeback and issue signals of the register file, grouped as one bus.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = NRD_DEF
);
    localparam int AW = addr_width(NREG);

    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic [AW:0]         busy_count;

    modport master (
        output rs_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rs_data, rs_busy, busy_count
    );

    modport slave (
        input  rs_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rs_data, rs_busy, busy_count
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending (busy) bits with a registered population count and NRD lookup ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int BYPASS = 1,
    localparam int AW    = addr_width(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NRD*AW-1:0] lookup_addr,
    output logic [NRD-1:0]    lookup_busy,
    output logic [AW:0]       busy_count
);

    logic [NREG-1:0] busy_r;
    logic [AW:0]     count_r;
    logic            alloc_ok_s;
    logic            wr_ok_s;
    logic            set_new_s;
    logic            clr_real_s;

    // Decode which busy bits actually flip this cycle; a same-address alloc keeps the bit set.
    always_comb begin
        alloc_ok_s = alloc_en && (alloc_addr != {AW{1'b0}});
        wr_ok_s    = wr_en && (wr_addr != {AW{1'b0}});
        set_new_s  = alloc_ok_s && !busy_r[alloc_addr];
        clr_real_s = wr_ok_s && busy_r[wr_addr] &&
                     !(alloc_ok_s && (alloc_addr == wr_addr));
    end

    // Busy bits and their count; alloc is applied after the clear so the new producer wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r  <= {NREG{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                busy_r[wr_addr] <= 1'b0;
            end
            if (alloc_ok_s) begin
                busy_r[alloc_addr] <= 1'b1;
            end
            count_r <= count_r + {{AW{1'b0}}, set_new_s} - {{AW{1'b0}}, clr_real_s};
        end
    end

    // Lookup: x0 is never busy, and a value being written this cycle is no longer pending.
    always_comb begin
        lookup_busy = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            if (lookup_addr[i*AW +: AW] == {AW{1'b0}}) begin
                lookup_busy[i] = 1'b0;
            end else if ((BYPASS != 0) && wr_ok_s && (wr_addr == lookup_addr[i*AW +: AW])) begin
                lookup_busy[i] = 1'b0;
            end else begin
                lookup_busy[i] = busy_r[lookup_addr[i*AW +: AW]];
            end
        end
    end

    assign busy_count = count_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: flop-based data array, optional write forwarding, pending scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          reset,
    regfile_mp_if.slave   bus
);

    localparam int AW = addr_width(NREG);

    logic [XLEN-1:0]     regs_r [NREG];
    logic [NRD*XLEN-1:0] rs_data_s;
    logic                wr_ok_s;

    assign wr_ok_s = bus.wr_en && (bus.wr_addr != {AW{1'b0}});

    // Data array; x0 is held at zero by never being a write target.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[bus.wr_addr] <= bus.wr_data;
        end else begin
            regs_r[0] <= {XLEN{1'b0}};
        end
    end

    // Combinational read ports with optional same-cycle forwarding of the writeback value.
    always_comb begin
        rs_data_s = {(NRD*XLEN){1'b0}};
        for (int i = 0; i < NRD; i++) begin
            if (bus.rs_addr[i*AW +: AW] == {AW{1'b0}}) begin
                rs_data_s[i*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if ((BYPASS != 0) && wr_ok_s && (bus.wr_addr == bus.rs_addr[i*AW +: AW])) begin
                rs_data_s[i*XLEN +: XLEN] = bus.wr_data;
            end else begin
                rs_data_s[i*XLEN +: XLEN] = regs_r[bus.rs_addr[i*AW +: AW]];
            end
        end
    end

    assign bus.rs_data = rs_data_s;

    regfile_scoreboard #(
        .NREG   (NREG),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .alloc_en    (bus.alloc_en),
        .alloc_addr  (bus.alloc_addr),
        .wr_en       (bus.wr_en),
        .wr_addr     (bus.wr_addr),
        .lookup_addr (bus.rs_addr),
        .lookup_busy (bus.rs_busy),
        .busy_count  (bus.busy_count)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and random checks of regfile_mp: a 4-port forwarding instance and a 2-port non-forwarding one.
module tb_regfile_mp;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    logic [31:0] mem_m  [32];
    logic [31:0] busy_m;

    regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(4)) bus4 ();
    regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) bus2 ();

    assign bus2.wr_en      = bus4.wr_en;
    assign bus2.wr_addr    = bus4.wr_addr;
    assign bus2.wr_data    = bus4.wr_data;
    assign bus2.alloc_en   = bus4.alloc_en;
    assign bus2.alloc_addr = bus4.alloc_addr;
    assign bus2.rs_addr    = bus4.rs_addr[9:0];

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(4), .BYPASS(1)) dut_byp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0)) dut_nobyp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic fwd(input logic [4:0] a, input bit byp);
        return byp && bus4.wr_en && (bus4.wr_addr != 5'd0) && (bus4.wr_addr == a);
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (fwd(a, byp)) return bus4.wr_data;
        return mem_m[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 1'b0;
        if (fwd(a, byp)) return 1'b0;
        return busy_m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
        busy_m = 32'd0;
    endtask

    // Architectural effect of one clock edge, from the register-file rules.
    task automatic model_update();
        if (reset) begin
            model_reset();
        end else begin
            if (bus4.wr_en && bus4.wr_addr != 5'd0) begin
                mem_m[bus4.wr_addr]  = bus4.wr_data;
                busy_m[bus4.wr_addr] = 1'b0;
            end
            if (bus4.alloc_en && bus4.alloc_addr != 5'd0) busy_m[bus4.alloc_addr] = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [4:0] a;
        for (int p = 0; p < 4; p++) begin
            a = bus4.rs_addr[p*5 +: 5];
            check("rd_byp", bus4.rs_data[p*32 +: 32], exp_data(a, 1'b1));
            check("busy_byp", 32'(bus4.rs_busy[p]), 32'(exp_busy(a, 1'b1)));
        end
        for (int p = 0; p < 2; p++) begin
            a = bus2.rs_addr[p*5 +: 5];
            check("rd_nobyp", bus2.rs_data[p*32 +: 32], exp_data(a, 1'b0));
            check("busy_nobyp", 32'(bus2.rs_busy[p]), 32'(exp_busy(a, 1'b0)));
        end
        check("count_byp", 32'(bus4.busy_count), 32'($countones(busy_m)));
        check("count_nobyp", 32'(bus2.busy_count), 32'($countones(busy_m)));
    endtask

    task automatic tick();
        #2;
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        bus4.wr_en    = 1'b0;
        bus4.alloc_en = 1'b0;
    endtask

    task automatic set_rs(input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] a3);
        bus4.rs_addr = {a3, a2, a1, a0};
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus4.wr_en   = 1'b1;
        bus4.wr_addr = a;
        bus4.wr_data = d;
    endtask

    task automatic alloc(input logic [4:0] a);
        bus4.alloc_en   = 1'b1;
        bus4.alloc_addr = a;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus4.wr_en = 1'b0; bus4.wr_addr = 5'd0; bus4.wr_data = 32'd0;
        bus4.alloc_en = 1'b0; bus4.alloc_addr = 5'd0;
        set_rs(5'd0, 5'd1, 5'd2, 5'd3);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        // Held in reset: outputs reflect cleared state, a requested write is ignored.
        wr(5'd2, 32'hCAFE_F00D); alloc(5'd6);
        set_rs(5'd1, 5'd6, 5'd3, 5'd0);
        tick();
        reset = 1'b0;
        idle();
        set_rs(5'd2, 5'd6, 5'd0, 5'd1);
        tick();

        // Register zero ignores writes and allocations.
        wr(5'd0, 32'hDEAD_BEEF); alloc(5'd0);
        set_rs(5'd0, 5'd0, 5'd0, 5'd0);
        tick();
        idle();
        tick();

        // Forwarding of x5 (old value 0 on the non-forwarding instance).
        wr(5'd5, 32'h1234_5678);
        set_rs(5'd5, 5'd5, 5'd5, 5'd1);
        tick();
        idle();
        tick();

        // Scoreboard alloc/writeback of x7.
        alloc(5'd7);
        set_rs(5'd7, 5'd7, 5'd0, 5'd5);
        tick();
        idle();
        tick();
        wr(5'd7, 32'h0000_00A5);
        tick();
        idle();
        tick();

        // Collision on already-busy x9.
        alloc(5'd9);
        set_rs(5'd9, 5'd9, 5'd7, 5'd0);
        tick();
        alloc(5'd9); wr(5'd9, 32'h0000_0055);
        tick();
        idle();
        tick();
        // Alloc to a busy register is accepted without moving the count.
        alloc(5'd9);
        tick();
        idle();

        // Multiport: three ports on x3, one on x0.
        wr(5'd3, 32'h0000_0077);
        tick();
        idle();
        set_rs(5'd3, 5'd3, 5'd0, 5'd3);
        tick();

        // Random traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            reset         = ($urandom_range(0, 49) == 0);
            bus4.wr_en    = 1'($urandom_range(0, 1));
            bus4.wr_addr  = 5'($urandom_range(0, 31));
            bus4.wr_data  = $urandom;
            bus4.alloc_en = 1'($urandom_range(0, 1));
            bus4.alloc_addr = ($urandom_range(0, 3) == 0) ? bus4.wr_addr : 5'($urandom_range(0, 31));
            bus4.rs_addr  = 20'($urandom);
            if ($urandom_range(0, 3) == 0) bus4.rs_addr[4:0] = bus4.wr_addr;
            if ($urandom_range(0, 3) == 0) bus4.rs_addr[9:5] = bus4.alloc_addr;
            tick();
        end
        reset = 1'b0;

        // Fill, allocate ten, then reset together with a write.
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), $urandom | 32'h1);
            set_rs(5'(i), 5'(i - 1), 5'($urandom_range(0, 31)), 5'(31 - i));
            tick();
        end
        idle();
        for (int k = 0; k < 10; k++) begin
            alloc(5'(2 + 2 * k));
            set_rs(5'(2 + 2 * k), 5'(1 + 2 * k), 5'(k), 5'(30 - k));
            tick();
        end
        idle();
        reset = 1'b1;
        wr(5'd4, 32'h0BAD_0BAD); alloc(5'd11);
        set_rs(5'd1, 5'd2, 5'd3, 5'd5);
        tick();
        reset = 1'b0;
        idle();
        for (int k = 0; k < 8; k++) begin
            set_rs(5'(4 * k), 5'(4 * k + 1), 5'(4 * k + 2), 5'(4 * k + 3));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits.
REQ-002 Parameter NREG, default 32: register count, power of two, minimum 2; AW = log2(NREG).
REQ-003 Parameter NRD, default 2: number of independent read ports, range 1..4.
REQ-004 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding enabled; 0 = disabled.
REQ-005 Port clk  in  1: single clock; all state updates on the rising edge.
REQ-006 Port reset  in  1: synchronous, active-high reset.
REQ-007 Port rs_addr  in  NRD*AW: read addresses; port i occupies bits [i*AW +: AW].
REQ-008 Port rs_data  out  NRD*XLEN: read data; port i occupies bits [i*XLEN +: XLEN].
REQ-009 Port rs_busy  out  NRD: bit i = operand on port i has a pending, unforwarded write.
REQ-010 Port wr_en  in  1: writeback strobe.
REQ-011 Port wr_addr  in  AW: writeback destination.
REQ-012 Port wr_data  in  XLEN: writeback value.
REQ-013 Port alloc_en  in  1: issue strobe; marks a destination as pending.
REQ-014 Port alloc_addr  in  AW: destination being allocated.
REQ-015 Port busy_count  out  AW+1: number of registers currently marked pending.

Function
REQ-016 Register 0 SHALL always read 0, ignore writes, and never be marked busy; this applies to both wr and alloc.
REQ-017 Reads SHALL be combinational: rs_data[i] = reg[rs_addr[i]], with zero cycles of latency.
REQ-018 A write with wr_en=1 and wr_addr!=0 SHALL update reg[wr_addr] at the rising edge.
REQ-019 Write bypass: with BYPASS=1, wr_en=1, wr_addr!=0 and wr_addr==rs_addr[i], rs_data[i] SHALL equal wr_data in the same cycle.
REQ-020 With BYPASS=0, rs_data[i] SHALL return the old value until the edge.
REQ-021 Each register SHALL hold one busy bit.
REQ-022 alloc_en=1 with alloc_addr!=0 SHALL set busy[alloc_addr] at the edge.
REQ-023 wr_en=1 with wr_addr!=0 SHALL clear busy[wr_addr] at the edge.
REQ-024 Simultaneous alloc and write to the same nonzero address: busy SHALL end at 1 (the new producer wins), and the data SHALL still be written.
REQ-025 Alloc to an already-busy register SHALL be accepted; busy stays 1 and busy_count is unchanged.
REQ-026 Write to a non-busy register SHALL update the data; busy stays 0.
REQ-027 rs_busy[i] = busy[rs_addr[i]], except rs_busy[i] SHALL be forced to 0 when BYPASS=1 and the REQ-019 forwarding condition holds.
REQ-028 rs_busy[i] SHALL be 0 whenever rs_addr[i]==0.
REQ-029 busy_count SHALL be registered and equal the population count of the busy bits after each edge.
REQ-030 busy_count SHALL change by -1, 0 or +1 per cycle.
REQ-031 The busy_count range is 0..NREG-1, and it SHALL never wrap.
REQ-032 All NRD read ports SHALL be fully independent; identical addresses on several ports SHALL return identical data and busy.

Reset
REQ-033 reset=1 at an edge SHALL clear all registers to 0, all busy bits to 0, and busy_count to 0.
REQ-034 reset SHALL override wr_en and alloc_en presented in the same cycle; neither takes effect.
REQ-035 During reset, outputs SHALL follow the combinational rules using the cleared state after the first reset edge.
REQ-036 Reset asserted mid-operation SHALL discard all pending state with no partial update.

Structure
REQ-037 Package regfile_pkg SHALL hold the XLEN/NREG/NRD defaults and the AW derivation function.
REQ-038 The busy bits, alloc/clear logic and busy_count SHALL live in sub-module regfile_scoreboard.
REQ-039 regfile_scoreboard SHALL be instantiated once, with NRD lookup ports.
REQ-040 The data array SHALL need no vendor macro and SHALL be synthesisable as flops.

Verification
REQ-041 Zero register: write 0xDEADBEEF to x0 and alloc x0 -> rs_data=0 and rs_busy=0 on all ports, and busy_count=0.
REQ-042 Bypass (BYPASS=1): wr x5=0x12345678 while rs_addr[0]=5 -> rs_data[0]=0x12345678 and rs_busy[0]=0 in the same cycle. With BYPASS=0, the old value is returned.
REQ-043 Scoreboard, step 1: alloc x7 -> next cycle rs_busy=1 for x7 and busy_count=1.
REQ-044 Scoreboard, step 2: then wr x7=0xA5 -> busy clears, busy_count=0, and x7 reads 0xA5.
REQ-045 Collision: alloc x9 and wr x9=0x55 in the same cycle (x9 previously busy) -> x9 reads 0x55, busy[9] stays 1, and busy_count is unchanged.
REQ-046 Reset: fill x1..x31 and allocate 10 registers, then pulse reset together with wr_en=1 -> all registers read 0, busy_count=0, and the write is lost.
REQ-047 Multiport: NRD=4, all ports at x3=0x77 plus one port at x0 -> three ports return 0x77, and the x0 port returns 0.
